// File: rtl/uart_rx.sv
// uart_rx: UART receiver with a 2-flop synchronizer and 3-sample majority vote per bit.
// Ports:
//   clk_i           system clock, OS x bit rate
//   rst_i           asynchronous active-high reset
//   rx_i            serial line, idle high, asynchronous to clk_i
//   parity_en_i     1 = frame carries a parity bit between data and stop
//   parity_type_i   0 = even, 1 = odd
//   p_data_o        last good word, only updated on a good frame
//   data_valid_o    one-cycle pulse: p_data_o holds a new good word
//   parity_error_o  one-cycle pulse: parity mismatch, frame dropped
//   stop_error_o    one-cycle pulse: stop bit voted 0, frame dropped
module uart_rx #(
    parameter int WIDTH = 8,
    parameter int OS    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rx_i,
    input  logic             parity_en_i,
    input  logic             parity_type_i,
    output logic [WIDTH-1:0] p_data_o,
    output logic             data_valid_o,
    output logic             parity_error_o,
    output logic             stop_error_o
);
    localparam int TW = $clog2(OS);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OS - 1);
    localparam logic [TW-1:0] T_S0   = TW'(OS / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OS / 2);
    localparam logic [TW-1:0] T_DEC  = TW'(OS / 2 + 1);
    localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state_q;
    logic [1:0]       sync_q;
    logic [TW-1:0]    tick_q;
    logic [BW-1:0]    bit_q;
    logic [WIDTH-1:0] shift_q;
    logic [1:0]       smp_q;
    logic             par_q;
    logic             en_q;
    logic             type_q;
    logic             rx_s;
    logic             vote;
    logic             wrap;
    logic             dec;
    logic             exp_par;

    assign rx_s = sync_q[1];
    // The third sample is the live synchronized value at the decision tick.
    assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    assign wrap    = tick_q == T_LAST;
    assign dec     = tick_q == T_DEC;
    assign exp_par = ^shift_q ^ type_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            sync_q         <= 2'b11;
            tick_q         <= '0;
            bit_q          <= '0;
            shift_q        <= '0;
            smp_q          <= 2'b11;
            par_q          <= 1'b0;
            en_q           <= 1'b0;
            type_q         <= 1'b0;
            p_data_o       <= '0;
            data_valid_o   <= 1'b0;
            parity_error_o <= 1'b0;
            stop_error_o   <= 1'b0;
        end else begin
            sync_q         <= {sync_q[0], rx_i};
            data_valid_o   <= 1'b0;
            parity_error_o <= 1'b0;
            stop_error_o   <= 1'b0;
            tick_q         <= (state_q == IDLE || wrap) ? '0 : tick_q + TW'(1);
            if (tick_q == T_S0) smp_q[0] <= rx_s;
            if (tick_q == T_S1) smp_q[1] <= rx_s;
            case (state_q)
                IDLE: begin
                    // The first low cycle is tick 0, so the next one is tick 1.
                    if (!rx_s) begin
                        state_q <= START;
                        tick_q  <= TW'(1);
                        en_q    <= parity_en_i;
                        type_q  <= parity_type_i;
                    end
                end
                START: begin
                    if (dec && vote) begin
                        state_q <= IDLE;
                        tick_q  <= '0;
                    end else if (wrap) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (dec) shift_q <= {vote, shift_q[WIDTH-1:1]};
                    if (wrap) begin
                        bit_q <= (bit_q == B_LAST) ? '0 : bit_q + BW'(1);
                        if (bit_q == B_LAST) state_q <= en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (dec) par_q <= vote;
                    if (wrap) state_q <= STOP;
                end
                STOP: begin
                    // Leave at the decision so a back-to-back start edge is not missed.
                    if (dec) begin
                        state_q <= IDLE;
                        tick_q  <= '0;
                        if (!vote) stop_error_o <= 1'b1;
                        else if (en_q && par_q != exp_par) parity_error_o <= 1'b1;
                        else begin
                            p_data_o     <= shift_q;
                            data_valid_o <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scoreboard bench for uart_rx.
module tb_uart_rx;
    localparam int OS  = 8;
    localparam int LAT = 2 + OS * (1 + 8) + OS / 2 + 2;

    typedef struct {
        logic [2:0] flags;
        logic [7:0] data;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       par_en;
    logic       par_type;
    logic [7:0] p_data;
    logic       dv;
    logic       pe;
    logic       se;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    logic [7:0] last_good = 8'h00;
    exp_t       sb[$];
    exp_t       e;

    uart_rx #(.WIDTH(8), .OS(OS)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .rx_i(rx),
        .parity_en_i(par_en),
        .parity_type_i(par_type),
        .p_data_o(p_data),
        .data_valid_o(dv),
        .parity_error_o(pe),
        .stop_error_o(se)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_pulse(input logic [2:0] flags, input logic [7:0] data, input int lat);
        exp_t x;
        x.flags = flags;
        x.data  = data;
        x.lat   = lat;
        sb.push_back(x);
    endtask

    // Called and returns on a falling edge; slen stretches/shrinks the start bit to skew the frame phase.
    task automatic send(input logic [7:0] d, input bit pen, input bit pbit, input bit sbit,
                        input int slen, input int gbit);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (slen) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < OS; c++) begin
                rx = (i == gbit && c == OS / 2) ? ~d[i] : d[i];
                @(negedge clk);
            end
        end
        if (pen) begin
            rx = pbit;
            repeat (OS) @(negedge clk);
        end
        rx = sbit;
        repeat (OS) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            last_good = 8'h00;
            check("reset_outputs", 32'({dv, pe, se, p_data}), 32'h0);
        end else begin
            if (dv | pe | se) begin
                check("one_pulse", $countones({dv, pe, se}), 1);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 32'({dv, pe, se}), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind", 32'({dv, pe, se}), 32'(e.flags));
                    if (e.flags == 3'b100) last_good = e.data;
                    if (e.lat > 0) check("latency", cyc - start_cyc, e.lat);
                end
            end
            check("p_data", 32'(p_data), 32'(last_good));
        end
    end

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        par_en = 1'b0;
        par_type = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(4);

        expect_pulse(3'b100, 8'hA5, LAT);
        send(8'hA5, 0, 0, 1, OS, -1);
        idle(2 * OS);

        par_en = 1'b1;
        par_type = 1'b0;
        expect_pulse(3'b100, 8'h3C, 0);
        send(8'h3C, 1, 0, 1, OS, -1);
        idle(2 * OS);
        expect_pulse(3'b010, 8'h00, 0);
        send(8'h3C, 1, 1, 1, OS, -1);
        idle(2 * OS);

        par_type = 1'b1;
        expect_pulse(3'b100, 8'h01, 0);
        send(8'h01, 1, 0, 1, OS, -1);
        idle(2 * OS);
        expect_pulse(3'b001, 8'h00, 0);
        send(8'h55, 1, 0, 0, OS, -1);
        idle(3 * OS);

        par_en = 1'b0;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(3 * OS);
        check("glitch_no_pulse", sb.size(), 0);

        expect_pulse(3'b100, 8'hF7, 0);
        send(8'hF7, 0, 0, 1, OS, 3);
        idle(2 * OS);
        expect_pulse(3'b100, 8'h08, 0);
        send(8'h08, 0, 0, 1, OS, 3);
        idle(2 * OS);

        expect_pulse(3'b100, 8'h12, 0);
        expect_pulse(3'b100, 8'h34, 0);
        expect_pulse(3'b100, 8'h56, 0);
        send(8'h12, 0, 0, 1, OS + 1, -1);
        send(8'h34, 0, 0, 1, OS - 1, -1);
        send(8'h56, 0, 0, 1, OS, -1);
        idle(2 * OS);

        rx = 1'b0;
        repeat (OS) @(negedge clk);
        rx = 1'b1;
        repeat (3 * OS) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2 * OS);
        expect_pulse(3'b100, 8'h81, 0);
        send(8'h81, 0, 0, 1, OS, -1);
        idle(2 * OS);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
